golden_nonce_reporter: RTL and testbench
========================================

# golden_nonce_reporter

Downstream stage of the miner top. It captures each golden-nonce strobe from the hashing core, buffers the nonces in a small FIFO, and emits each one as a 6-byte frame on a byte-wide valid/ready stream toward the host link (UART/JTAG bridge). The hashing clock never stalls: overflow drops the nonce and counts the drop, and back-pressure stays inside this block.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `hash_clk`  in  1  Single clock; hashing-core clock domain.
- `rst_n`  in  1  Reset; asynchronous, active-low.
- `nonce_valid`  in  1  One-cycle strobe: `nonce_in` holds a golden nonce.
- `nonce_in`  in  32  Golden nonce, already offset-corrected by the core.
- `tx_data`  out  8  Frame byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  Sink accepts the byte this cycle.
- `fifo_count`  out  $clog2(DEPTH)+1  Occupied FIFO entries.
- `drop_count`  out  16  Nonces lost to overflow; saturates at 16'hFFFF.
- `busy`  out  1  High when the FSM is not IDLE or the FIFO is non-empty.

## Operation
- Frame: SYNC_BYTE, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0], CHK. CHK is the XOR of the four nonce bytes.
- Push: on `nonce_valid`, write `nonce_in` if `fifo_count < DEPTH`, or if a pop occurs in the same cycle. Otherwise discard it and increment `drop_count` (saturating).
- Pop: happens only in IDLE when the FIFO is non-empty. The head entry moves into a 32-bit frame register, and CHK is computed at the same time.
- FSM states: IDLE, SYNC, B3, B2, B1, B0, CHK.
  - IDLE: if the FIFO is non-empty, pop and go to SYNC. Otherwise stay in IDLE.
  - SYNC through CHK: advance one state on each handshake (`tx_valid && tx_ready`).
  - CHK: on handshake, return to IDLE.
- `tx_valid` is 1 in every state except IDLE. `tx_data` is selected by state from the frame register and is registered, so the output is glitch-free.
- Handshake rules:
  - While `tx_valid && !tx_ready`, `tx_data` and the state hold.
  - `tx_valid` never drops until its byte is accepted.
  - `tx_ready` may toggle arbitrarily; the block does not depend on it being asserted in IDLE.
- Width rules:
  - FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
  - `fifo_count` is one bit wider, so it can represent a full FIFO.
  - `drop_count` never wraps.
- Reset (`rst_n` low, at any time including mid-frame):
  - Immediately forces IDLE, `tx_valid` = 0, `tx_data` = 8'h00, `fifo_count` = 0, `drop_count` = 0, `busy` = 0.
  - Pointers are cleared and buffered nonces are lost.
  - A partially sent frame is abandoned; the sink resynchronises on SYNC_BYTE.

## Timing
- Strobe at cycle t with the FSM in IDLE and the FIFO empty: the FIFO is non-empty at t+1, the pop occurs at the end of t+1, and `tx_valid` rises at t+2 with `tx_data` = SYNC_BYTE.
- With `tx_ready` held at 1, a frame occupies 6 consecutive cycles, followed by one IDLE bubble before the next frame. Sustained throughput is 1 nonce per 7 cycles.
- `fifo_count` updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- When a push arrives while the FIFO is full and a pop happens in the same cycle, the push is accepted and nothing is dropped.

## Structure
- Shared miner package:
  - frame-state enum (IDLE, SYNC, B3, B2, B1, B0, CHK)
  - `FRAME_BYTES` = 6
  - default SYNC_BYTE constant
- One sub-module, `nonce_fifo`: synchronous single-clock FIFO with `DEPTH` and width parameters, push/pop/full/empty/count, and asynchronous active-low reset.
- The FSM, frame register, checksum and drop counter live in the top of this block.

## Test plan
- Single nonce 32'hDEADBEEF with `tx_ready` = 1 -> from t+2, bytes A5, DE, AD, BE, EF, CHK. CHK = DE^AD^BE^EF = 8'h22. Then `busy` = 0.
- Same nonce with `tx_ready` toggling 1,0,0,1,… -> byte sequence identical; `tx_data` stable during every stall; no duplicated or skipped bytes.
- `tx_ready` = 0 and 6 strobes (nonces 1..6) with `DEPTH` = 4 -> 1 popped into the frame register and 2..5 buffered; 6 dropped; `drop_count` = 1; `fifo_count` = 4. After releasing `tx_ready`, frames for 1, 2, 3, 4, 5 emerge in order.
- FIFO full and a strobe in the same cycle as an IDLE pop -> nonce accepted, `drop_count` unchanged, `fifo_count` stays at `DEPTH`.
- `rst_n` asserted during byte B2 of a frame -> `tx_valid` drops the same cycle without waiting for a clock; after release, a new strobe 32'h00000081 yields a complete frame A5, 00, 00, 00, 81, 81.
- Drop saturation: force `drop_count` near its limit (or strobe 65 540 times into a full FIFO with `tx_ready` = 0) -> the counter holds at 16'hFFFF.

Source files
------------

// File: rtl/golden_nonce_reporter_pkg.sv
// Shared miner definitions: frame-state encoding, frame geometry, default
// sync byte and the frame checksum helper.
package golden_nonce_reporter_pkg;

  localparam int unsigned NONCE_W           = 32;
  localparam int unsigned FRAME_BYTES       = 6;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_B3   = 3'd2,
    ST_B2   = 3'd3,
    ST_B1   = 3'd4,
    ST_B0   = 3'd5,
    ST_CHK  = 3'd6
  } frame_state_e;

  // XOR of the four nonce bytes
  function automatic logic [7:0] nonce_chk(input logic [NONCE_W-1:0] n);
    return n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
  endfunction

endpackage

// File: rtl/golden_nonce_reporter_nonce_fifo.sv
// Single-clock FIFO for golden nonces.
// Ports: clk/rst_n (async active-low), push/wr_data write side,
// pop/rd_data_c read side (head entry, combinational), full_c/empty_c flags,
// count = occupied entries (registered, one bit wider than the pointers).
module nonce_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage needs no reset: occupancy is tracked by the pointers/count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/golden_nonce_reporter.sv
// Golden-nonce reporter: buffers nonce strobes from the hashing core and
// sends each as a 6-byte frame (sync, 4 nonce bytes MSB first, XOR checksum)
// on a byte-wide valid/ready stream. Never stalls the core; overflow drops.
// Ports: hash_clk, rst_n (async active-low); nonce_valid/nonce_in strobe in;
// tx_data/tx_valid/tx_ready byte stream out; fifo_count, drop_count
// (saturating), busy status.
module golden_nonce_reporter
  import golden_nonce_reporter_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                   hash_clk,
  input  logic                   rst_n,
  input  logic                   nonce_valid,
  input  logic [31:0]            nonce_in,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            drop_count,
  output logic                   busy
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned DROP_W = 16;

  frame_state_e        state_q, state_d;
  logic [NONCE_W-1:0]  frame_q, frame_d;
  logic [7:0]          chk_q, chk_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                busy_q, busy_d;

  logic                hs_c, push_c, pop_c, full_c, empty_c;
  logic [NONCE_W-1:0]  head_c;
  logic [CNT_W-1:0]    cnt_next_c;

  nonce_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk       (hash_clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .wr_data   (nonce_in),
    .pop       (pop_c),
    .rd_data_c (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .count     (fifo_count)
  );

  assign hs_c = tx_valid_q & tx_ready;

  // Frame FSM, push/drop policy and next output values
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    chk_d   = chk_q;
    pop_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          frame_d = head_c;
          chk_d   = nonce_chk(head_c);
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: if (hs_c) state_d = ST_B3;
      ST_B3:   if (hs_c) state_d = ST_B2;
      ST_B2:   if (hs_c) state_d = ST_B1;
      ST_B1:   if (hs_c) state_d = ST_B0;
      ST_B0:   if (hs_c) state_d = ST_CHK;
      ST_CHK:  if (hs_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A same-cycle pop frees a slot, so a full FIFO can still accept
    push_c = nonce_valid & (~full_c | pop_c);

    drop_d = drop_q;
    if (nonce_valid && !push_c && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end

    // Output byte is chosen from the next state so it is ready with tx_valid
    tx_valid_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_SYNC: tx_data_d = SYNC_BYTE;
      ST_B3:   tx_data_d = frame_d[31:24];
      ST_B2:   tx_data_d = frame_d[23:16];
      ST_B1:   tx_data_d = frame_d[15:8];
      ST_B0:   tx_data_d = frame_d[7:0];
      ST_CHK:  tx_data_d = chk_d;
      default: tx_data_d = 8'h00;
    endcase

    cnt_next_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    busy_d     = tx_valid_d | (cnt_next_c != '0);
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      chk_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      drop_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      chk_q      <= chk_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign drop_count = drop_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Bench for golden_nonce_reporter: directed tables, hand sequences for
// stalls/overflow/reset, randomized traffic against a queue-based model.
module tb_golden_nonce_reporter;
  import golden_nonce_reporter_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             hash_clk = 1'b0;
  logic             rst_n;
  logic             nonce_valid;
  logic [31:0]      nonce_in;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [CNT_W-1:0] fifo_count;
  logic [15:0]      drop_count;
  logic             busy;

  golden_nonce_reporter #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .hash_clk    (hash_clk),
    .rst_n       (rst_n),
    .nonce_valid (nonce_valid),
    .nonce_in    (nonce_in),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 hash_clk = ~hash_clk;

  int checks = 0;
  int errors = 0;

  // Model: nonces waiting, bytes left of the frame on the wire, byte stream owed
  logic [31:0] mq[$];
  logic [7:0]  mframe[$];
  logic [7:0]  exp_stream[$];
  int          m_drop;

  typedef struct {
    logic        v;
    logic [31:0] n;
    logic        r;
    logic        ev;
    logic [7:0]  ed;
    logic [2:0]  ec;
    logic        eb;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [31:0] x, input int k);
    case (k)
      0: return SYNC_BYTE_DEFAULT;
      1: return x[31:24];
      2: return x[23:16];
      3: return x[15:8];
      4: return x[7:0];
      default: return x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0];
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    mframe.delete();
    exp_stream.delete();
    m_drop = 0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] n, input logic r);
    bit in_f, hs, pop, acc;
    logic [31:0] x;
    in_f = (mframe.size() > 0);
    hs   = in_f && r;
    pop  = !in_f && (mq.size() > 0);
    acc  = v && ((mq.size() < DEPTH) || pop);
    if (hs) void'(mframe.pop_front());
    if (pop) begin
      x = mq.pop_front();
      for (int k = 0; k < FRAME_BYTES; k++) mframe.push_back(frame_byte(x, k));
    end
    if (acc) begin
      mq.push_back(n);
      for (int k = 0; k < FRAME_BYTES; k++) exp_stream.push_back(frame_byte(n, k));
    end else if (v && m_drop < 65535) begin
      m_drop++;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".tx_valid"}, 32'(tx_valid), 32'(mframe.size() > 0));
    check({tag, ".tx_data"}, 32'(tx_data), (mframe.size() > 0) ? 32'(mframe[0]) : 32'h0);
    check({tag, ".fifo_count"}, 32'(fifo_count), 32'(mq.size()));
    check({tag, ".drop_count"}, 32'(drop_count), 32'(m_drop));
    check({tag, ".busy"}, 32'(busy), 32'((mframe.size() > 0) || (mq.size() > 0)));
  endtask

  // One clock: drive at negedge, score handshake byte, model edge, compare
  task automatic cycle(input logic v, input logic [31:0] n, input logic r, input string tag);
    nonce_valid = v;
    nonce_in    = n;
    tx_ready    = r;
    #1;
    if (tx_valid && r) begin
      if (exp_stream.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s.stream: got unexpected byte %0h expected none", tag, tx_data);
      end else begin
        check({tag, ".stream"}, 32'(tx_data), 32'(exp_stream.pop_front()));
      end
    end
    @(posedge hash_clk);
    model_edge(v, n, r);
    #1;
    compare_model(tag);
    @(negedge hash_clk);
  endtask

  task automatic reset_dut();
    nonce_valid = 1'b0;
    nonce_in    = '0;
    tx_ready    = 1'b0;
    rst_n       = 1'b0;
    @(negedge hash_clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget; k++) cycle(1'b0, 32'h0, 1'b1, tag);
    check({tag, ".stream_left"}, 32'(exp_stream.size()), 32'h0);
    check({tag, ".busy_end"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp81[6];
    logic [1:0] tog_pat[4];
    model_reset();

    // Reset state
    rst_n = 1'b0; nonce_valid = 1'b0; nonce_in = '0; tx_ready = 1'b0;
    #1;
    check("rst.tx_valid", 32'(tx_valid), 32'h0);
    check("rst.tx_data", 32'(tx_data), 32'h0);
    check("rst.fifo_count", 32'(fifo_count), 32'h0);
    check("rst.drop_count", 32'(drop_count), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    @(negedge hash_clk);
    rst_n = 1'b1;

    // Single DEADBEEF frame, tx_ready held high
    tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 3'd1, 1'b1};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b1};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 8'hDE, 3'd0, 1'b1};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 8'hAD, 3'd0, 1'b1};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 8'hBE, 3'd0, 1'b1};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 8'hEF, 3'd0, 1'b1};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 8'h22, 3'd0, 1'b1};
    tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].v, tbl[i].n, tbl[i].r, "tbl");
      check($sformatf("tbl%0d.tx_valid", i), 32'(tx_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d.tx_data", i), 32'(tx_data), 32'(tbl[i].ed));
      check($sformatf("tbl%0d.fifo_count", i), 32'(fifo_count), 32'(tbl[i].ec));
      check($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].eb));
    end

    // Same nonce with tx_ready toggling 1,0,0,1
    tog_pat[0] = 2'd1; tog_pat[1] = 2'd0; tog_pat[2] = 2'd0; tog_pat[3] = 2'd1;
    cycle(1'b1, 32'hDEADBEEF, 1'b1, "tog");
    for (int i = 0; i < 30; i++) cycle(1'b0, 32'h0, tog_pat[i % 4][0], "tog");
    drain("tog", 4);

    // Overflow with tx_ready low: 1 in frame, 2..5 buffered, 6 dropped
    reset_dut();
    for (int i = 1; i <= 6; i++) cycle(1'b1, 32'(i), 1'b0, "ovf");
    check("ovf.drop_count", 32'(drop_count), 32'h1);
    check("ovf.fifo_count", 32'(fifo_count), 32'h4);
    for (int k = 0; k < 20; k++) begin
      if (mframe.size() == 0) break;
      cycle(1'b0, 32'h0, 1'b1, "ovf_drain");
    end
    check("full_idle.fifo_count", 32'(fifo_count), 32'h4);
    check("full_idle.tx_valid", 32'(tx_valid), 32'h0);
    // Strobe into full FIFO in the IDLE-pop cycle: must be accepted
    cycle(1'b1, 32'h00000077, 1'b1, "poppush");
    check("poppush.drop_count", 32'(drop_count), 32'h1);
    check("poppush.fifo_count", 32'(fifo_count), 32'h4);
    drain("ovf_tail", 50);

    // Reset during B2 of a frame, then a clean frame for 32'h00000081
    reset_dut();
    cycle(1'b1, 32'hCAFEF00D, 1'b1, "midrst");
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, "midrst");
    check("midrst.b2_data", 32'(tx_data), 32'hFE);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.tx_valid", 32'(tx_valid), 32'h0);
    check("midrst.tx_data", 32'(tx_data), 32'h0);
    check("midrst.busy", 32'(busy), 32'h0);
    check("midrst.fifo_count", 32'(fifo_count), 32'h0);
    @(negedge hash_clk);
    rst_n = 1'b1;
    model_reset();
    exp81[0] = 8'hA5; exp81[1] = 8'h00; exp81[2] = 8'h00;
    exp81[3] = 8'h00; exp81[4] = 8'h81; exp81[5] = 8'h81;
    cycle(1'b1, 32'h00000081, 1'b1, "f81");
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 32'h0, 1'b1, "f81");
      check($sformatf("f81.byte%0d", k), 32'(tx_data), 32'(exp81[k]));
    end
    drain("f81", 2);

    // Randomized traffic
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 4) == 0, $urandom, ($urandom % 3) != 0, "rnd");
    end
    drain("rnd", 60);

    // Drop counter saturation
    reset_dut();
    for (int i = 0; i < 65545; i++) cycle(1'b1, 32'(i), 1'b0, "sat");
    check("sat.drop_count", 32'(drop_count), 32'hFFFF);
    cycle(1'b1, 32'h12345678, 1'b0, "sat_hold");
    check("sat_hold.drop_count", 32'(drop_count), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
